// File: rtl/vec_scalar_operand_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vec_scalar_operand_fetch : vector-side requester for the scalar rs1 read
// port; returns tagged operands (with write-event bypass) through a FIFO.
// Revision: 1.0
// ============================================================================
module vec_scalar_operand_fetch #(
   parameter int DEPTH        = 4,
   parameter int TAG_W        = 4,
   parameter int STARVE_LIMIT = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [4:0]       req_rs1_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic             rs1_addr_Ven_o,
   output logic [5:0]       rs1_addr_o,
   input  logic [63:0]      rs1_data_i,
   input  logic             port_gnt_i,
   output logic             stall_scalar_o,
   input  logic [69:0]      reg_file_wr_event_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [63:0]      rsp_data_o,
   output logic [TAG_W-1:0] rsp_tag_o
);

   localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W = $clog2(DEPTH + 1);
   localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);
   localparam logic [c_STV_W-1:0] c_STV_MAX  = c_STV_W'(STARVE_LIMIT);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [4:0]         r_idx;
   logic [TAG_W-1:0]   r_tag;
   logic [c_STV_W-1:0] r_starve;
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic [63:0]        r_mem_data [DEPTH];
   logic [TAG_W-1:0]   r_mem_tag  [DEPTH];

   logic               w_push;
   logic [63:0]        w_push_data;
   logic [TAG_W-1:0]   w_push_tag;
   logic               w_pop;
   logic               w_latch;
   logic               w_ready;
   logic               w_nonempty;
   logic               w_ev_hit;

   assign w_nonempty = (r_count != '0);
   assign w_pop      = w_nonempty & rsp_ready_i;
   // A scalar write landing on the same register this cycle is newer than the read port data.
   assign w_ev_hit   = reg_file_wr_event_i[0] & (reg_file_wr_event_i[69:65] == r_idx);

   always_comb begin
      w_state_nxt    = r_state;
      w_push         = 1'b0;
      w_push_data    = '0;
      w_push_tag     = '0;
      w_latch        = 1'b0;
      w_ready        = 1'b0;
      rs1_addr_Ven_o = 1'b0;
      rs1_addr_o     = '0;
      stall_scalar_o = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = ~rst_i & ~flush_i & (r_count < c_DEPTH);
            if (req_valid_i && w_ready) begin
               if (req_rs1_i == 5'd0) begin
                  w_push     = 1'b1;
                  w_push_tag = req_tag_i;
               end else begin
                  w_latch     = 1'b1;
                  w_state_nxt = S_REQ;
               end
            end
         end
         S_REQ: begin
            rs1_addr_Ven_o = 1'b1;
            rs1_addr_o     = {1'b0, r_idx};
            stall_scalar_o = (r_starve >= c_STV_MAX);
            if (port_gnt_i) begin
               w_push      = 1'b1;
               w_push_data = w_ev_hit ? reg_file_wr_event_i[64:1] : rs1_data_i;
               w_push_tag  = r_tag;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush_i) begin
         w_state_nxt = S_IDLE;
         w_push      = 1'b0;
         w_latch     = 1'b0;
      end
   end

   assign req_ready_o = w_ready;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_tag   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch) begin
            r_idx <= req_rs1_i;
            r_tag <= req_tag_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i || (r_state != S_REQ) || port_gnt_i) begin
         r_starve <= '0;
      end else if (r_starve != c_STV_MAX) begin
         r_starve <= r_starve + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= w_push_data;
         r_mem_tag[r_wr_ptr]  <= w_push_tag;
      end
   end

   assign rsp_valid_o = w_nonempty;
   assign rsp_data_o  = w_nonempty ? r_mem_data[r_rd_ptr] : '0;
   assign rsp_tag_o   = w_nonempty ? r_mem_tag[r_rd_ptr]  : '0;

endmodule
`default_nettype wire

// File: tb/tb_vec_scalar_operand_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_vec_scalar_operand_fetch : randomized scoreboard bench for the operand fetch.
// Revision: 1.0
// ============================================================================
module tb_vec_scalar_operand_fetch;

   localparam int DEPTH        = 4;
   localparam int TAG_W        = 4;
   localparam int STARVE_LIMIT = 16;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             flush_i;
   logic             req_valid_i;
   logic             req_ready_o;
   logic [4:0]       req_rs1_i;
   logic [TAG_W-1:0] req_tag_i;
   logic             rs1_addr_Ven_o;
   logic [5:0]       rs1_addr_o;
   logic [63:0]      rs1_data_i;
   logic             port_gnt_i;
   logic             stall_scalar_o;
   logic [69:0]      reg_file_wr_event_i;
   logic             rsp_valid_o;
   logic             rsp_ready_i;
   logic [63:0]      rsp_data_o;
   logic [TAG_W-1:0] rsp_tag_o;

   vec_scalar_operand_fetch #(
      .DEPTH(DEPTH), .TAG_W(TAG_W), .STARVE_LIMIT(STARVE_LIMIT)
   ) u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_rs1_i(req_rs1_i), .req_tag_i(req_tag_i),
      .rs1_addr_Ven_o(rs1_addr_Ven_o), .rs1_addr_o(rs1_addr_o),
      .rs1_data_i(rs1_data_i), .port_gnt_i(port_gnt_i),
      .stall_scalar_o(stall_scalar_o), .reg_file_wr_event_i(reg_file_wr_event_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_tag_o(rsp_tag_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [63:0]      d;
      logic [TAG_W-1:0] t;
   } exp_t;

   exp_t             sb[$];
   int               checks = 0;
   int               errors = 0;
   // Reference model: one outstanding register read, plus how long it has waited.
   bit               pend = 1'b0;
   logic [4:0]       pidx = '0;
   logic [TAG_W-1:0] ptag = '0;
   int               waited = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [69:0] mk_ev(input logic [4:0] a, input logic [63:0] d, input bit v);
      return {a, d, v};
   endfunction

   task automatic model_clear();
      sb.delete();
      pend   = 1'b0;
      waited = 0;
   endtask

   // One clock of stimulus; checks request-side outputs and advances the model.
   task automatic step(input bit v, input logic [4:0] r, input logic [TAG_W-1:0] t,
                       input bit g, input logic [63:0] d, input logic [69:0] e,
                       input bit rdy, input bit fl);
      bit   exp_ready;
      exp_t x;
      @(posedge clk_i);
      #1;
      req_valid_i = v; req_rs1_i = r; req_tag_i = t;
      port_gnt_i = g; rs1_data_i = d; reg_file_wr_event_i = e;
      rsp_ready_i = rdy & ~fl; flush_i = fl;
      #1;
      exp_ready = !pend && (sb.size() < DEPTH) && !fl;
      chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
      chk("ven", 64'(rs1_addr_Ven_o), 64'(pend));
      chk("rs1_addr", 64'(rs1_addr_o), pend ? 64'(pidx) : 64'd0);
      chk("stall", 64'(stall_scalar_o), 64'(pend && waited >= STARVE_LIMIT));
      chk("rsp_valid", 64'(rsp_valid_o), 64'(sb.size() != 0));
      if (fl) begin
         model_clear();
      end else if (pend) begin
         if (g) begin
            x.d = (e[0] && e[69:65] == pidx) ? e[64:1] : d;
            x.t = ptag;
            sb.push_back(x);
            pend   = 1'b0;
            waited = 0;
         end else begin
            waited++;
         end
      end else if (v && exp_ready) begin
         if (r == 5'd0) begin
            x.d = 64'd0;
            x.t = t;
            sb.push_back(x);
         end else begin
            pend = 1'b1; pidx = r; ptag = t; waited = 0;
         end
      end
   endtask

   task automatic idle(input bit rdy);
      step(1'b0, 5'd0, '0, 1'b0, 64'd0, 70'd0, rdy, 1'b0);
   endtask

   always @(negedge clk_i) begin
      exp_t e;
      if (!rst_i && rsp_valid_o && rsp_ready_i) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got data %0h tag %0h, none expected", rsp_data_o, rsp_tag_o);
         end else begin
            e = sb.pop_front();
            chk("rsp_data", rsp_data_o, e.d);
            chk("rsp_tag", 64'(rsp_tag_o), 64'(e.t));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [4:0]  ra;
      logic [63:0] rd;
      rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; req_rs1_i = '0; req_tag_i = '0;
      rs1_data_i = '0; port_gnt_i = 1'b0; reg_file_wr_event_i = '0; rsp_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #2;
      chk("reset_ready", 64'(req_ready_o), 64'd0);
      chk("reset_ven", 64'(rs1_addr_Ven_o), 64'd0);
      chk("reset_stall", 64'(stall_scalar_o), 64'd0);
      chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
      rst_i = 1'b0;
      model_clear();

      // Granted immediately
      step(1'b1, 5'd5, 4'd3, 1'b0, 64'd0, 70'd0, 1'b1, 1'b0);
      step(1'b0, 5'd0, 4'd0, 1'b1, 64'hDEAD_BEEF_0000_0005, 70'd0, 1'b1, 1'b0);
      repeat (2) idle(1'b1);
      // x0 shortcut
      step(1'b1, 5'd0, 4'd7, 1'b0, 64'd0, 70'd0, 1'b1, 1'b0);
      repeat (2) idle(1'b1);
      // Starvation, then grant
      step(1'b1, 5'd9, 4'd2, 1'b0, 64'd0, 70'd0, 1'b1, 1'b0);
      repeat (20) step(1'b0, 5'd0, 4'd0, 1'b0, 64'd0, 70'd0, 1'b1, 1'b0);
      step(1'b0, 5'd0, 4'd0, 1'b1, 64'h5555_0000_AAAA_0009, 70'd0, 1'b1, 1'b0);
      repeat (2) idle(1'b1);
      // Write-event bypass hit and miss
      step(1'b1, 5'd9, 4'd4, 1'b0, 64'd0, 70'd0, 1'b1, 1'b0);
      step(1'b0, 5'd0, 4'd0, 1'b1, 64'hFFFF, mk_ev(5'd9, 64'h1234, 1'b1), 1'b1, 1'b0);
      step(1'b1, 5'd9, 4'd5, 1'b0, 64'd0, 70'd0, 1'b1, 1'b0);
      step(1'b0, 5'd0, 4'd0, 1'b1, 64'hFFFF, mk_ev(5'd10, 64'h1234, 1'b1), 1'b1, 1'b0);
      repeat (2) idle(1'b1);
      // FIFO fills with consumer stalled; fifth request waits for the first pop
      for (int i = 0; i < 5; i++) step(1'b1, 5'd0, 4'(i + 8), 1'b0, 64'd0, 70'd0, 1'b0, 1'b0);
      step(1'b1, 5'd0, 4'd12, 1'b0, 64'd0, 70'd0, 1'b1, 1'b0);
      step(1'b1, 5'd0, 4'd12, 1'b0, 64'd0, 70'd0, 1'b1, 1'b0);
      repeat (6) idle(1'b1);
      // Flush while a read is outstanding and two results are queued
      step(1'b1, 5'd0, 4'd1, 1'b0, 64'd0, 70'd0, 1'b0, 1'b0);
      step(1'b1, 5'd0, 4'd2, 1'b0, 64'd0, 70'd0, 1'b0, 1'b0);
      step(1'b1, 5'd3, 4'd3, 1'b0, 64'd0, 70'd0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 4'd0, 1'b1, 64'h77, 70'd0, 1'b0, 1'b1);
      step(1'b1, 5'd6, 4'd6, 1'b0, 64'd0, 70'd0, 1'b1, 1'b0);
      step(1'b0, 5'd0, 4'd0, 1'b1, 64'h0606, 70'd0, 1'b1, 1'b0);
      repeat (2) idle(1'b1);

      for (int n = 0; n < 600; n++) begin
         ra = ($urandom % 2 == 0) ? pidx : 5'($urandom);
         rd = {$urandom, $urandom};
         step(($urandom % 3) != 0,
              ($urandom % 4 == 0) ? 5'd0 : 5'($urandom),
              4'($urandom),
              ($urandom % 3) == 0,
              {$urandom, $urandom},
              mk_ev(ra, rd, ($urandom % 2) == 1),
              ($urandom % 4) != 0,
              ($urandom % 40) == 0);
      end

      // Reset while a read is outstanding
      step(1'b1, 5'd7, 4'd1, 1'b0, 64'd0, 70'd0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 4'd0, 1'b0, 64'd0, 70'd0, 1'b0, 1'b0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1; rsp_ready_i = 1'b0; port_gnt_i = 1'b0; req_valid_i = 1'b0;
      @(posedge clk_i);
      #2;
      chk("midreset_ven", 64'(rs1_addr_Ven_o), 64'd0);
      chk("midreset_rsp_valid", 64'(rsp_valid_o), 64'd0);
      rst_i = 1'b0;
      model_clear();
      repeat (2) idle(1'b1);

      for (int k = 0; k < 40 && (sb.size() != 0 || pend); k++)
         step(1'b0, 5'd0, 4'd0, 1'b1, 64'h0, 70'd0, 1'b1, 1'b0);
      idle(1'b1);
      chk("drain_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vec_scalar_operand_fetch.md
Name: vec_scalar_operand_fetch

Overview:
- Vector-side requester for the scalar register file's shared rs1 read port.
- Accepts scalar-operand requests from the vector issue logic and drives rs1_addr_Ven / rs1_addr toward the scalar datapath.
- Captures the combinational rs1 data, with write-event bypass, and returns tagged results through a small FIFO with valid/ready handshake.
- Sits between the vector issue queue and the scalar datapath's vector read interface.

Parameters:
- DEPTH, 4, result FIFO entries (power of 2, >=2).
- TAG_W, 4, request/response tag width.
- STARVE_LIMIT, 16, REQ-state cycles without grant before stall_scalar_o is asserted.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  synchronous kill of in-flight request and FIFO contents.
- req_valid_i  in  1  operand request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_rs1_i  in  5  scalar register index.
- req_tag_i  in  TAG_W  tag returned with data.
- rs1_addr_Ven_o  out  1  claims scalar rs1 read port.
- rs1_addr_o  out  6  read address, {1'b0, index}.
- rs1_data_i  in  64  combinational read data from datapath (valid while Ven high).
- port_gnt_i  in  1  scalar pipeline has yielded rs1 port this cycle.
- stall_scalar_o  out  1  starvation request to scalar control unit.
- reg_file_wr_event_i  in  70  {addr[69:65], data[64:1], valid[0]} scalar write event.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  consumer ready.
- rsp_data_o  out  64  operand value.
- rsp_tag_o  out  TAG_W  tag.

Behaviour:
- Decided: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset (rst_i=1 at clk edge): state=IDLE, FIFO empty, starve counter=0. All outputs 0 except req_ready_o, which becomes 1 after reset releases.
- FSM states: IDLE, REQ.
- IDLE:
  - req_ready_o = (count < DEPTH) & ~flush_i.
  - On accept with req_rs1_i==0: push {64'b0, tag} at the same edge; stay IDLE. rsp_valid_o at T+1; port is never claimed.
  - On accept with req_rs1_i!=0: latch index and tag, go to REQ.
- REQ:
  - rs1_addr_Ven_o=1, rs1_addr_o={1'b0, idx}, req_ready_o=0.
  - If port_gnt_i=1: capture and push at that edge, return to IDLE.
  - Captured data: if reg_file_wr_event_i[0] & addr==idx, use event data; else rs1_data_i.
  - Latency for a granted first cycle: accept T, Ven at T+1, rsp_valid_o at T+2.
- Starvation:
  - Counter increments each REQ cycle without grant; clears on grant, flush or leaving REQ.
  - stall_scalar_o=1 when counter >= STARVE_LIMIT, held until grant. Counter saturates.
- FIFO:
  - rsp_* are driven from the head entry; pop on rsp_valid_o & rsp_ready_i.
  - Simultaneous push and pop: count unchanged, ordering preserved.
  - Pointers wrap modulo DEPTH; count width is clog2(DEPTH+1).
  - No overflow is possible: acceptance requires count<DEPTH and only one request is in flight. A pop on the capture edge is allowed.
- flush_i (priority below rst_i, above everything else):
  - Next state IDLE, FIFO emptied, starve counter cleared, any same-cycle push discarded.
  - rs1_addr_Ven_o is deasserted from the next cycle.
  - req_ready_o=0 during the flush cycle.
- Ven is never asserted in IDLE; rs1_addr_o=0 when Ven=0.
- stall_scalar_o is never asserted outside REQ.
- Reset mid-REQ: Ven drops the cycle after the reset edge; no response is produced.

Test Plan:
- Request rs1=5, tag=3, port_gnt_i=1 immediately, rs1_data_i=64'hDEAD_BEEF_0000_0005 -> Ven high 1 cycle with rs1_addr_o=6'd5; rsp_valid_o at T+2 with data 64'hDEAD_BEEF_0000_0005, tag 3.
- Request rs1=0, tag=7 -> no Ven; rsp_valid_o at T+1, data 0, tag 7.
- Request rs1=9 with gnt held 0 for 20 cycles, STARVE_LIMIT=16 -> stall_scalar_o rises after 16 REQ cycles. Then gnt=1 -> capture, stall drops next cycle, response delivered.
- Grant cycle with reg_file_wr_event_i={5'd9, 64'h1234, 1'b1}, rs1_data_i=64'hFFFF, idx=9 -> rsp_data_o=64'h1234. Same case with event addr 10 -> 64'hFFFF.
- rsp_ready_i=0, issue 5 requests with DEPTH=4 -> 4 accepted, req_ready_o=0 at count 4. Raise rsp_ready_i -> results in order, 5th request accepted after the first pop.
- Assert flush_i in REQ with 2 entries queued -> Ven low next cycle, rsp_valid_o=0, count=0. A following request behaves normally.
